i2s_dsp_frame_ctrl: RTL and testbench
=====================================

Name: i2s_dsp_frame_ctrl

Overview:
Frame sequencer for the I2S DSP-mode transmit channel when the SoC is frame master. It gates the channel enable, waits for the channel to report it is primed, and generates the frame-sync (ws) pulse and slot/bit position counters. It stops the channel only on frame boundaries and flags FIFO underruns at word boundaries. It sits between the uDMA I2S register file and the TX DSP channel, in the sck_i domain.

Parameters:
GAP_W, 4, width of cfg_gap_i (idle bit-clocks inserted between frames)

Ports:
sck_i  in  1  bit clock; all state on rising edge
rstn_i  in  1  asynchronous active-low reset
cfg_en_i  in  1  software enable request
cfg_num_bits_i  in  5  bits per word minus 1
cfg_num_word_i  in  4  words per frame minus 1
cfg_gap_i  in  GAP_W  idle bit-clocks between frames (0 = back-to-back)
cfg_long_fs_i  in  1  long frame sync select (see Optional Feature)
tx_ready_i  in  1  channel primed (channel master_ready_to_send)
fifo_data_valid_i  in  1  TX FIFO has data
ch_en_o  out  1  drives channel cfg_en_i
ws_o  out  1  frame sync to channel and pad
frame_active_o  out  1  high in FRAME state
word_idx_o  out  4  current slot index
bit_idx_o  out  5  current bit index within slot
underrun_o  out  1  one-cycle pulse on underrun
underrun_sticky_o  out  1  latched underrun, cleared on IDLE entry

Behaviour:
- Reset: state=IDLE. All outputs 0. Counters 0. Shadow config 0.
- All outputs are registered. No combinational path from input to output.
- Shadow config: num_bits, num_word and gap are latched on IDLE->ARM and at every frame end. Changes take effect only on frame boundaries.
- IDLE:
  - ch_en_o=0, ws_o=0, underrun_sticky_o cleared.
  - cfg_en_i=1 -> ARM.
- ARM:
  - ch_en_o=1.
  - cfg_en_i=0 -> IDLE next cycle, abort allowed.
  - tx_ready_i=1 -> FRAME. On the same edge: ws_o=1, word_idx=0, bit_idx=0.
- FRAME:
  - bit_idx increments each cycle.
  - When bit_idx==num_bits: bit_idx wraps to 0 and word_idx increments.
  - ws_o is high only for the first cycle (word 0, bit 0).
  - Frame length is exactly (num_bits+1)*(num_word+1) cycles.
- Frame end (word_idx==num_word and bit_idx==num_bits):
  - cfg_en_i=0 -> IDLE; ch_en_o drops on that edge.
  - Otherwise gap==0 -> new frame immediately: ws_o=1, counters 0, no dead cycle.
  - Otherwise -> GAP.
- GAP:
  - ws_o=0, ch_en_o=1; counts gap cycles.
  - On the last gap cycle: cfg_en_i=1 -> FRAME with ws_o=1, else -> IDLE.
- cfg_en_i falling mid-frame or mid-gap is ignored until the boundary. This is a graceful stop; a frame is never truncated.
- tx_ready_i is sampled only in ARM. A drop during FRAME has no effect.
- Underrun check (FRAME only):
  - Sampled when bit_idx==num_bits and fifo_data_valid_i==0, except on the final word of a frame that ends in IDLE.
  - Result: underrun_o pulses one cycle and underrun_sticky_o sets. The sequence continues.
- num_bits=0 (1-bit words) and num_word=0 (1 slot) are legal. A 1x1 frame gives ws_o high every cycle when gap==0.

Optional Feature:
- Macro: I2S_DSP_LONG_FS_EN.
- Defined, cfg_long_fs_i=1: ws_o stays high for the whole of word 0 (num_bits+1 cycles) and drops at word 1 bit 0. With num_word=0 it is high for the whole frame.
- Defined, cfg_long_fs_i=0: single-cycle pulse.
- Undefined: cfg_long_fs_i is ignored and ws_o is always the single-cycle pulse.

Test Plan:
- Basic framing: num_bits=15, num_word=1, gap=0, tx_ready_i high 3 cycles after cfg_en_i -> ws_o one-cycle pulse every 32 cycles; bit_idx 0..15 then word_idx 1.
- Gap: num_bits=7, num_word=0, gap=3 -> ws_o period 11 cycles; frame_active_o low for 3 cycles between frames.
- Graceful stop: cfg_en_i dropped at word 0 bit 4 (num_bits=7, num_word=1) -> ch_en_o stays high until the edge after word 1 bit 7, then IDLE; no further ws_o.
- Abort in ARM: cfg_en_i 1 for 5 cycles with tx_ready_i=0 -> ch_en_o high 5 cycles then 0; ws_o never asserted.
- Underrun: fifo_data_valid_i=0 at word 0 bit num_bits -> underrun_o one pulse, sticky set; sticky cleared after IDLE re-entry.
- Config change: num_bits written 15->7 mid-frame -> current frame completes with 16-bit words; next frame uses 8-bit words. With I2S_DSP_LONG_FS_EN and cfg_long_fs_i=1, ws_o is high for 8 cycles.

Source files
------------

// File: rtl/i2s_dsp_frame_ctrl.sv
// i2s_dsp_frame_ctrl: DSP-mode I2S frame sequencer (channel gating, ws pulse, slot/bit counters, underrun flag).
// Define I2S_DSP_LONG_FS_EN to let cfg_long_fs_i hold ws high for all of word 0.
module i2s_dsp_frame_ctrl #(
    parameter int GAP_W = 4
) (
    input  logic             sck_i,
    input  logic             rstn_i,
    input  logic             cfg_en_i,
    input  logic [4:0]       cfg_num_bits_i,
    input  logic [3:0]       cfg_num_word_i,
    input  logic [GAP_W-1:0] cfg_gap_i,
    input  logic             cfg_long_fs_i,
    input  logic             tx_ready_i,
    input  logic             fifo_data_valid_i,
    output logic             ch_en_o,
    output logic             ws_o,
    output logic             frame_active_o,
    output logic [3:0]       word_idx_o,
    output logic [4:0]       bit_idx_o,
    output logic             underrun_o,
    output logic             underrun_sticky_o
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ARM   = 2'd1;
    localparam logic [1:0] FRAME = 2'd2;
    localparam logic [1:0] GAP   = 2'd3;

    logic [1:0]       state, nxt_state;
    logic [4:0]       sh_bits, nxt_bit;
    logic [3:0]       sh_word, nxt_word;
    logic [GAP_W-1:0] sh_gap, gap_cnt;
    logic             sh_long, last_bit, frame_end, latch_cfg, frame_cont, ur_hit, nxt_ws;

`ifdef I2S_DSP_LONG_FS_EN
    always_ff @(posedge sck_i or negedge rstn_i)
        if (!rstn_i)
            sh_long <= 1'b0;
        else if (latch_cfg)
            sh_long <= cfg_long_fs_i;
`else
    logic unused_long_fs;
    assign sh_long        = 1'b0;
    assign unused_long_fs = cfg_long_fs_i;
`endif

    assign last_bit   = bit_idx_o == sh_bits;
    assign frame_end  = state == FRAME && last_bit && word_idx_o == sh_word;
    assign frame_cont = state == FRAME && !frame_end;
    assign latch_cfg  = (state == IDLE && cfg_en_i) || frame_end;
    // the last word of a stopping frame is never refilled, so it cannot underrun
    assign ur_hit     = state == FRAME && last_bit && !fifo_data_valid_i && !(frame_end && !cfg_en_i);

    always_comb begin
        nxt_state = state;
        case (state)
            IDLE:    nxt_state = cfg_en_i ? ARM : IDLE;
            ARM:     nxt_state = !cfg_en_i ? IDLE : tx_ready_i ? FRAME : ARM;
            FRAME:   nxt_state = !frame_end ? FRAME : !cfg_en_i ? IDLE : cfg_gap_i == '0 ? FRAME : GAP;
            default: nxt_state = gap_cnt != '0 ? GAP : cfg_en_i ? FRAME : IDLE;
        endcase
        nxt_bit  = frame_cont && !last_bit ? bit_idx_o + 5'd1 : 5'd0;
        nxt_word = frame_cont ? (last_bit ? word_idx_o + 4'd1 : word_idx_o) : 4'd0;
        nxt_ws   = nxt_state == FRAME && nxt_word == 4'd0 && (nxt_bit == 5'd0 || sh_long);
    end

    always_ff @(posedge sck_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state             <= IDLE;
            sh_bits           <= '0;
            sh_word           <= '0;
            sh_gap            <= '0;
            gap_cnt           <= '0;
            ch_en_o           <= 1'b0;
            ws_o              <= 1'b0;
            frame_active_o    <= 1'b0;
            word_idx_o        <= '0;
            bit_idx_o         <= '0;
            underrun_o        <= 1'b0;
            underrun_sticky_o <= 1'b0;
        end else begin
            state             <= nxt_state;
            if (latch_cfg) begin
                sh_bits <= cfg_num_bits_i;
                sh_word <= cfg_num_word_i;
                sh_gap  <= cfg_gap_i;
            end
            gap_cnt           <= frame_end ? cfg_gap_i - GAP_W'(1) : state == GAP ? gap_cnt - GAP_W'(1) : gap_cnt;
            ch_en_o           <= nxt_state != IDLE;
            ws_o              <= nxt_ws;
            frame_active_o    <= nxt_state == FRAME;
            word_idx_o        <= nxt_word;
            bit_idx_o         <= nxt_bit;
            underrun_o        <= ur_hit;
            underrun_sticky_o <= nxt_state == IDLE ? 1'b0 : underrun_sticky_o | ur_hit;
        end
    end

    logic unused_sh_gap;
    assign unused_sh_gap = ^sh_gap;
endmodule

// File: tb/tb_i2s_dsp_frame_ctrl.sv
// tb_i2s_dsp_frame_ctrl: directed and random stimulus against a frame-position reference model, checked by a scoreboard.
module tb_i2s_dsp_frame_ctrl;
    localparam int GAP_W = 4;
`ifdef I2S_DSP_LONG_FS_EN
    localparam bit LONG = 1'b1;
`else
    localparam bit LONG = 1'b0;
`endif

    logic sck = 1'b0, rstn = 1'b0;
    logic en = 1'b0, rdy = 1'b0, fv = 1'b1, lfs = 1'b0;
    logic [4:0] cb = '0;
    logic [3:0] cw = '0;
    logic [GAP_W-1:0] cg = '0;
    logic ch_en, ws, fa, ur, urs;
    logic [3:0] widx;
    logic [4:0] bidx;
    logic [13:0] exp_q[$];
    logic [13:0] mon_e, mon_g;
    int total = 0, bad = 0, cyc = 0;
    int ph = 0, p = 0, g = 0, nb = 0, nw = 0, gp = 0;
    bit sl = 1'b0, st = 1'b0;

    always #5 sck = ~sck;

    i2s_dsp_frame_ctrl #(.GAP_W(GAP_W)) dut (
        .sck_i(sck), .rstn_i(rstn), .cfg_en_i(en), .cfg_num_bits_i(cb), .cfg_num_word_i(cw),
        .cfg_gap_i(cg), .cfg_long_fs_i(lfs), .tx_ready_i(rdy), .fifo_data_valid_i(fv),
        .ch_en_o(ch_en), .ws_o(ws), .frame_active_o(fa), .word_idx_o(widx), .bit_idx_o(bidx),
        .underrun_o(ur), .underrun_sticky_o(urs)
    );

    assign mon_g = {ch_en, ws, fa, widx, bidx, ur, urs};

    task automatic latch_cfg();
        nb = int'(cb); nw = int'(cw); gp = int'(cg); sl = lfs;
    endtask

    // ph: 0 idle, 1 armed, 2 in frame at position p, 3 in gap with g cycles left
    task automatic step_model();
        int len;
        bit u, e_ch, e_ws, e_fa;
        logic [3:0] e_w;
        logic [4:0] e_b;
        u = 1'b0;
        len = (nb + 1) * (nw + 1);
        case (ph)
            0: if (en) begin latch_cfg(); ph = 1; end
            1: if (!en) ph = 0; else if (rdy) begin ph = 2; p = 0; end
            2: begin
                if (p % (nb + 1) == nb && !fv && !(p == len - 1 && !en)) u = 1'b1;
                if (p == len - 1) begin
                    latch_cfg();
                    p = 0;
                    if (!en) ph = 0;
                    else if (gp != 0) begin ph = 3; g = gp; end
                end else p++;
            end
            default: begin
                g--;
                if (g == 0) begin ph = en ? 2 : 0; p = 0; end
            end
        endcase
        st = (ph == 0) ? 1'b0 : (st | u);
        e_ch = ph != 0;
        e_fa = ph == 2;
        e_ws = e_fa && (p == 0 || (LONG && sl && p <= nb));
        e_w = e_fa ? 4'(p / (nb + 1)) : 4'd0;
        e_b = e_fa ? 5'(p % (nb + 1)) : 5'd0;
        exp_q.push_back({e_ch, e_ws, e_fa, e_w, e_b, u, st});
    endtask

    task automatic drive(input bit e, input bit r, input bit f, input int n);
        for (int i = 0; i < n; i++) begin
            en = e; rdy = r; fv = f;
            step_model();
            @(negedge sck);
        end
    endtask

    task automatic set_cfg(input int b, input int w, input int gg);
        cb = 5'(b); cw = 4'(w); cg = GAP_W'(gg);
    endtask

    initial begin
        forever begin
            @(posedge sck);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                total++;
                if (mon_g !== mon_e) begin
                    bad++;
                    $display("FAIL outputs cycle=%0d {ch_en,ws,fa,word,bit,ur,sticky} got=%b_%b_%b_%h_%h_%b_%b exp=%b_%b_%b_%h_%h_%b_%b",
                             cyc, mon_g[13], mon_g[12], mon_g[11], mon_g[10:7], mon_g[6:2], mon_g[1], mon_g[0],
                             mon_e[13], mon_e[12], mon_e[11], mon_e[10:7], mon_e[6:2], mon_e[1], mon_e[0]);
                end
            end
        end
    end

    initial begin
        bit re;
        en = 1'b1; rdy = 1'b1; fv = 1'b0; cb = 5'd3; cg = 4'd2;
        repeat (3) @(negedge sck);
        total++;
        if (mon_g !== 14'd0) begin
            bad++;
            $display("FAIL reset got=%b exp=%b", mon_g, 14'd0);
        end
        en = 1'b0; rdy = 1'b0; fv = 1'b1;
        rstn = 1'b1;
        // basic framing, tx_ready 3 cycles late, ready drop mid-frame ignored
        set_cfg(15, 1, 0);
        drive(1, 0, 1, 3);
        drive(1, 1, 1, 1);
        drive(1, 0, 1, 40);
        set_cfg(7, 1, 0);
        drive(1, 0, 1, 40);
        // graceful stop mid word 0
        drive(1, 0, 1, 5);
        drive(0, 0, 1, 30);
        // abort in ARM
        drive(1, 0, 1, 5);
        drive(0, 0, 1, 3);
        // gap between frames
        set_cfg(7, 0, 3);
        lfs = 1'b1;
        drive(1, 1, 1, 40);
        drive(0, 0, 1, 15);
        // underruns, then sticky clear on return to IDLE
        set_cfg(3, 1, 0);
        drive(1, 1, 0, 12);
        drive(1, 1, 1, 4);
        drive(0, 1, 0, 20);
        drive(1, 0, 1, 2);
        // 1x1 back-to-back frames
        set_cfg(0, 0, 0);
        drive(1, 1, 1, 10);
        drive(0, 0, 1, 4);
        re = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                cb = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 15)) : 5'($urandom_range(0, 3));
                cw = 4'($urandom_range(0, 3));
                cg = GAP_W'($urandom_range(0, 3));
                lfs = 1'($urandom_range(0, 1));
            end
            if (re ? $urandom_range(0, 79) == 0 : $urandom_range(0, 9) == 0) re = ~re;
            drive(re, 1'($urandom_range(0, 1)), $urandom_range(0, 9) != 0, 1);
        end
        repeat (3) @(negedge sck);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
